// File: rtl/wb_stage_pkg.sv
// Shared constants for the writeback stage: default widths, RISC-V load funct3 encodings
// and the natural-alignment helper used when WB_MISALIGN_CHECK_EN is defined.
package wb_stage_pkg;

  localparam int DEFAULT_XLEN   = 64;
  localparam int DEFAULT_REG_AW = 5;
  localparam int DEFAULT_CNT_W  = 64;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Access size comes from funct3[1:0]; at XLEN=32 a doubleword encoding behaves as a word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] addr_lo,
                                         input int xlen);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = |addr_lo[1:0];
      default: mis = (xlen == 64) ? |addr_lo : |addr_lo[1:0];
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load aligner: shifts the raw memory word down to the addressed byte,
// then truncates and sign- or zero-extends according to funct3.
module wb_load_ext
  import wb_stage_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      f3,
  output logic [XLEN-1:0] data
);

  logic [2:0]      off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] word_sext;

  always_comb begin
    off       = (XLEN == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
    shifted   = word >> {off, 3'b000};
    word_sext = XLEN'($signed(shifted[31:0]));
    data      = '0;
    case (f3)
      LB:      data = XLEN'($signed(shifted[7:0]));
      LH:      data = XLEN'($signed(shifted[15:0]));
      LW:      data = word_sext;
      LBU:     data = XLEN'(shifted[7:0]);
      LHU:     data = XLEN'(shifted[15:0]);
      // On a 32-bit core ld, lwu and 111 all collapse to lw.
      LD:      data = (XLEN == 64) ? shifted : word_sext;
      LWU:     data = (XLEN == 64) ? XLEN'(shifted[31:0]) : word_sext;
      default: data = (XLEN == 64) ? '0 : word_sext;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: one-entry pipeline register with valid/ready, stall and flush,
// x0 write suppression, forwarding bus and retire counter. Optional: WB_MISALIGN_CHECK_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int REG_AW = DEFAULT_REG_AW,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              reg_we_i,
  input  logic [REG_AW-1:0] reg_waddr_i,
  input  logic [XLEN-1:0]   reg_wdata_i,
  input  logic              is_load_i,
  input  logic [2:0]        load_f3_i,
  input  logic [2:0]        addr_lo_i,
  output logic              reg_we_o,
  output logic [REG_AW-1:0] reg_waddr_o,
  output logic [XLEN-1:0]   reg_wdata_o,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_addr_o,
  output logic [XLEN-1:0]   fwd_data_o,
`ifdef WB_MISALIGN_CHECK_EN
  output logic              misalign_o,
`endif
  output logic [CNT_W-1:0]  retire_cnt_o
);

  // Handshake: an instruction transfers on a rising edge when valid_i && ready_o; flush_i
  // cancels only that arriving instruction, never the entry already held here.
  logic              valid_q;
  logic              we_q;
  logic              mis_q;
  logic [REG_AW-1:0] waddr_q;
  logic [XLEN-1:0]   data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              capture;
  logic              commit;
  logic              live;
  logic              mis_d;
  logic [XLEN-1:0]   ext_data;
  logic [XLEN-1:0]   next_data;

  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .word    (reg_wdata_i),
    .addr_lo (addr_lo_i),
    .f3      (load_f3_i),
    .data    (ext_data)
  );

  assign ready_o   = !stall_i;
  assign capture   = valid_i && ready_o && !flush_i;
  assign commit    = valid_q && !stall_i;
  assign next_data = is_load_i ? ext_data : reg_wdata_i;

`ifdef WB_MISALIGN_CHECK_EN
  assign mis_d      = is_load_i && is_misaligned(load_f3_i, addr_lo_i, XLEN);
  assign misalign_o = valid_q && mis_q;
`else
  assign mis_d      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else if (!stall_i) begin
      valid_q <= capture;
      if (capture) begin
        we_q    <= reg_we_i;
        mis_q   <= mis_d;
        waddr_q <= reg_waddr_i;
        data_q  <= next_data;
      end
      // A commit happens in the single cycle the entry leaves, so it counts once.
      if (commit && !mis_q) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign live         = valid_q && we_q && (waddr_q != '0) && !mis_q;
  assign reg_we_o     = live && !stall_i;
  assign reg_waddr_o  = waddr_q;
  assign reg_wdata_o  = data_q;
  assign fwd_valid_o  = live;
  assign fwd_addr_o   = waddr_q;
  assign fwd_data_o   = data_q;
  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage (default build, XLEN=64): directed scenarios plus a random stream,
// with expected register writes queued at drive time and matched as writes appear.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, flush_i, stall_i;
  logic        reg_we_i, is_load_i;
  logic [4:0]  reg_waddr_i;
  logic [63:0] reg_wdata_i;
  logic [2:0]  load_f3_i, addr_lo_i;
  logic        reg_we_o, fwd_valid_o;
  logic [4:0]  reg_waddr_o, fwd_addr_o;
  logic [63:0] reg_wdata_o, fwd_data_o, retire_cnt_o;

  logic [68:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          writes_seen = 0;
  logic [63:0] exp_cnt = 0;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .stall_i(stall_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .reg_wdata_i(reg_wdata_i), .is_load_i(is_load_i), .load_f3_i(load_f3_i),
    .addr_lo_i(addr_lo_i), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o),
    .fwd_data_o(fwd_data_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference extraction built byte by byte from the architectural definition.
  function automatic logic [63:0] ref_load(input logic [63:0] w, input logic [2:0] a,
                                           input logic [2:0] f3);
    logic [63:0] r = '0;
    int nbytes;
    if (f3 == 3'b111) return '0;
    nbytes = 1 << f3[1:0];
    for (int i = 0; i < nbytes; i++)
      if (int'(a) + i < 8) r[i*8 +: 8] = w[(int'(a) + i)*8 +: 8];
    if (!f3[2] && nbytes < 8 && r[nbytes*8-1])
      for (int i = nbytes; i < 8; i++) r[i*8 +: 8] = 8'hFF;
    return r;
  endfunction

  // Scoreboard side: every observed write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && reg_we_o) begin
      writes_seen++;
      if (exp_q.size() == 0) check("unexpected_write", {59'd0, reg_waddr_o}, 64'd0);
      else begin
        logic [68:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {59'd0, reg_waddr_o}, {59'd0, e[68:64]});
        check("wr_data", reg_wdata_o, e[63:0]);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one instruction for one edge; called just after a rising edge.
  task automatic send(input logic we, input logic [4:0] waddr, input logic [63:0] wdata,
                      input logic ld, input logic [2:0] f3, input logic [2:0] alo,
                      input logic [63:0] exp_data);
    valid_i = 1'b1; reg_we_i = we; reg_waddr_i = waddr; reg_wdata_i = wdata;
    is_load_i = ld; load_f3_i = f3; addr_lo_i = alo;
    if (we && waddr != 5'd0) exp_q.push_back({waddr, exp_data});
    exp_cnt++;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 0; flush_i = 0; stall_i = 0; reg_we_i = 0; is_load_i = 0;
    reg_waddr_i = '0; reg_wdata_i = '0; load_f3_i = '0; addr_lo_i = '0;
    #12;
    check("rst_we", {63'd0, reg_we_o}, 64'd0);
    check("rst_fwd_valid", {63'd0, fwd_valid_o}, 64'd0);
    check("rst_waddr", {59'd0, reg_waddr_o}, 64'd0);
    check("rst_wdata", reg_wdata_o, 64'd0);
    check("rst_fwd_data", fwd_data_o, 64'd0);
    check("rst_cnt", retire_cnt_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // ALU write: visible the cycle after acceptance
    send(1, 5'd5, 64'h1234, 0, 3'b000, 3'd0, 64'h1234);
    check("alu_fwd_valid", {63'd0, fwd_valid_o}, 64'd1);
    check("alu_fwd_addr", {59'd0, fwd_addr_o}, 64'd5);
    idle(1);
    check("alu_cnt", retire_cnt_o, 64'd1);

    // Directed loads, back to back
    send(1, 5'd6, 64'h8000_0000_0000_0000, 1, 3'b000, 3'd7, 64'hFFFF_FFFF_FFFF_FF80);
    send(1, 5'd7, 64'h8000_0000_0000_0000, 1, 3'b100, 3'd7, 64'h80);
    send(1, 5'd8, 64'h0000_BEEF_0000_0000, 1, 3'b101, 3'd4, 64'hBEEF);
    send(1, 5'd9, 64'h1122_3344_5566_7788, 1, 3'b111, 3'd0, 64'h0);
    idle(1);
    check("load_cnt", retire_cnt_o, exp_cnt);

    // Stall: held entry writes and counts exactly once
    send(1, 5'd10, 64'hCAFE, 0, 3'b000, 3'd0, 64'hCAFE);
    stall_i = 1'b1;
    begin
      int w0;
      w0 = writes_seen;
      for (int i = 0; i < 3; i++) begin
        #1;
        check("stall_ready", {63'd0, ready_o}, 64'd0);
        check("stall_we", {63'd0, reg_we_o}, 64'd0);
        check("stall_fwd", {63'd0, fwd_valid_o}, 64'd1);
        check("stall_cnt", retire_cnt_o, exp_cnt - 64'd1);
        idle(1);
      end
      stall_i = 1'b0;
      idle(3);
      check("stall_pulses", 64'(writes_seen - w0), 64'd1);
      check("stall_cnt_after", retire_cnt_o, exp_cnt);
    end

    // Flush alongside a new instruction while entry A is held
    send(1, 5'd11, 64'hAAAA, 0, 3'b000, 3'd0, 64'hAAAA);
    valid_i = 1'b1; flush_i = 1'b1; reg_we_i = 1'b1; reg_waddr_i = 5'd12;
    reg_wdata_i = 64'hBBBB; is_load_i = 1'b0;
    idle(1);
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_we", {63'd0, reg_we_o}, 64'd0);
    check("flush_fwd", {63'd0, fwd_valid_o}, 64'd0);
    check("flush_cnt", retire_cnt_o, exp_cnt);

    // Write to x0: counted, never written or forwarded
    send(1, 5'd0, 64'hDEAD, 0, 3'b000, 3'd0, 64'hDEAD);
    check("x0_we", {63'd0, reg_we_o}, 64'd0);
    check("x0_fwd", {63'd0, fwd_valid_o}, 64'd0);
    idle(1);
    check("x0_cnt", retire_cnt_o, exp_cnt);

    // Random stream of ALU ops and loads, with occasional stalls between
    for (int i = 0; i < 60; i++) begin
      logic [63:0] w;
      logic [2:0]  f3, alo;
      logic        ld;
      w   = {$urandom, $urandom};
      f3  = 3'($urandom_range(0, 7));
      alo = 3'($urandom_range(0, 7));
      ld  = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), w, ld, f3, alo,
           ld ? ref_load(w, alo, f3) : w);
      if ($urandom_range(0, 5) == 0) begin
        stall_i = 1'b1;
        idle($urandom_range(1, 3));
        stall_i = 1'b0;
      end
    end
    idle(2);
    check("rand_cnt", retire_cnt_o, exp_cnt);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset while holding a stalled entry: discarded, no later write
    send(1, 5'd13, 64'h5555, 0, 3'b000, 3'd0, 64'h5555);
    stall_i = 1'b1;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check("mid_rst_we", {63'd0, reg_we_o}, 64'd0);
    check("mid_rst_fwd", {63'd0, fwd_valid_o}, 64'd0);
    check("mid_rst_wdata", reg_wdata_o, 64'd0);
    check("mid_rst_cnt", retire_cnt_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_i = 1'b0;
    begin
      int w0;
      w0 = writes_seen;
      idle(3);
      check("post_rst_writes", 64'(writes_seen - w0), 64'd0);
      check("post_rst_cnt", retire_cnt_o, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Registered, parametrised writeback stage; successor to the combinational pass-through writeback.
- Sits between the MEM stage and the register file. Holds one instruction in a pipeline register with a valid/ready handshake, stall and flush.
- Aligns and sign- or zero-extends load data and suppresses writes to x0.
- Drives the register-file write port, a forwarding bus and a retired-instruction counter.

Parameters:
XLEN, 64, register/data width (32 or 64)
REG_AW, 5, register address width
CNT_W, 64, retire counter width

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  MEM presents an instruction
ready_o  output  1  stage can accept; equals !stall_i
flush_i  input  1  kill the instruction arriving this cycle
stall_i  input  1  freeze the WB register (downstream commit busy)
reg_we_i  input  1  instruction writes a register
reg_waddr_i  input  REG_AW  destination register
reg_wdata_i  input  XLEN  ALU result, or raw 64-bit-aligned memory word for loads
is_load_i  input  1  wdata is a memory read word
load_f3_i  input  3  RISC-V funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
addr_lo_i  input  3  byte offset of the load address
reg_we_o  output  1  register-file write enable
reg_waddr_o  output  REG_AW  register-file write address
reg_wdata_o  output  XLEN  register-file write data
fwd_valid_o  output  1  WB holds a live register-writing result
fwd_addr_o  output  REG_AW  forwarding address
fwd_data_o  output  XLEN  forwarding data
retire_cnt_o  output  CNT_W  instructions retired since reset

Behaviour:
- Reset (rst_n=0, asynchronous): valid_q=0; retire_cnt_o=0; reg_we_o=0; fwd_valid_o=0; reg_waddr_o, reg_wdata_o, fwd_addr_o and fwd_data_o all 0.
- Reset mid-operation discards the held instruction without a write or a count.
- Capture: on a rising edge with valid_i && ready_o && !flush_i, load the payload and set valid_q=1. Load extension happens before the register, so WB data is final.
- No capture and no stall: valid_q goes to 0.
- flush_i has priority over capture. It never kills the entry already held in WB, which is older and must commit.
- Stall: while stall_i=1, all registers hold, ready_o=0 and reg_we_o=0.
- Commit: the held entry commits in the first cycle with valid_q && !stall_i.
  - reg_we_o = valid_q && we_q && (waddr_q != 0) && !stall_i.
  - Each entry produces exactly one write pulse and one count, however long it was stalled.
- Latency: one cycle from acceptance to reg_we_o when not stalled. Throughput is one instruction per cycle.
- Forwarding: fwd_valid_o = valid_q && we_q && waddr_q != 0, independent of stall. fwd_addr_o and fwd_data_o mirror the held entry.
- Load extension:
  - Shift the word right by addr_lo_i*8.
  - Take 8, 16, 32 or 64 bits per funct3; sign-extend for lb/lh/lw and zero-extend for lbu/lhu/lwu.
  - When XLEN=32: ld, lwu and funct3 111 behave as lw, and only addr_lo_i[1:0] is used.
  - Undefined funct3 (111 at XLEN=64) yields data 0.
- Non-load: data passes through unchanged.
- Retire counter: increments by 1 on every commit, including entries with we=0 and writes to x0. It wraps modulo 2^CNT_W.
- Write to x0: accepted and counted, but reg_we_o stays 0.

Optional Feature:
- WB_MISALIGN_CHECK_EN defined:
  - Adds output misalign_o. It is registered with the entry and asserted while valid_q and the load's addr_lo_i is not naturally aligned for its size.
  - A misaligned entry does not assert reg_we_o or fwd_valid_o and is not counted.
- Undefined: no port; misaligned loads are extracted as if aligned at the shifted offset.

Decomposition:
- Shared package/defines: XLEN, REG_AW and the funct3 load encodings as named constants (LB, LH, LW, LD, LBU, LHU, LWU).
- One natural sub-module: wb_load_ext. It is purely combinational, takes (word, addr_lo, f3) and returns the XLEN result, and is unit-testable on its own.

Test Plan:
- Reset then an ALU write: valid_i=1, we=1, waddr=5, wdata=0x1234 -> next cycle reg_we_o=1, addr 5, data 0x1234, retire_cnt_o=1.
- lb, word 0x80_00..00, addr_lo=7 -> data 0xFFFF_FFFF_FFFF_FF80. Same stimulus as lbu -> 0x80. lhu, word 0x0000_BEEF_0000_0000, addr_lo=4 -> 0xBEEF.
- Stall: capture an entry, hold stall_i=1 for 3 cycles -> reg_we_o=0 and the counter is unchanged during the stall. On release, exactly one write pulse and counter +1; ready_o=0 throughout the stall.
- flush_i=1 together with valid_i=1 while WB holds entry A -> A commits next cycle. The flushed instruction never writes, and valid_q=0 afterwards.
- Write to x0 with wdata=0xDEAD -> reg_we_o=0, fwd_valid_o=0, counter +1.
- Assert rst_n=0 while holding a stalled entry -> all outputs 0 immediately; counter 0; no write after release.
